reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register in bits.
REQ-002 Parameter ADDR_W, default 4, address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary storage.
REQ-004 CLK  input  1  the single clock; all storage updates on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write enable, sampled on rising CLK edge.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_addr_a  input  ADDR_W  read port A address.
REQ-010 rd_addr_b  input  ADDR_W  read port B address.
REQ-011 rd_data_a  output  WIDTH  read port A data.
REQ-012 rd_data_b  output  WIDTH  read port B data.
REQ-013 wr_count  output  16  count of accepted writes since reset.

Function
REQ-014 Storage SHALL be DEPTH registers of WIDTH bits each, all independent.
REQ-015 On rising CLK with wr_en=1 and RST=0, register[wr_addr] SHALL load wr_data; no other register SHALL change.
REQ-016 With wr_en=0, every register SHALL hold its value indefinitely.
REQ-017 Read ports SHALL be combinational: rd_data_x = register[rd_addr_x], zero-cycle latency from address change.
REQ-018 Both read ports SHALL operate independently; equal addresses on A and B SHALL return identical data.
REQ-019 With ZERO_REG=1, rd_data_x SHALL be 0 whenever rd_addr_x=0, and a write to address 0 SHALL have no effect on storage.
REQ-020 A write is "accepted" when wr_en=1 at a rising edge and, if ZERO_REG=1, wr_addr!=0; wr_count SHALL increment by 1 per accepted write on that edge.
REQ-021 wr_count SHALL wrap from 16'hFFFF to 0 without saturation.
REQ-022 Data SHALL be stored and returned bit-exact; no sign extension, truncation or arithmetic.
REQ-023 A read of the address being written in the same cycle SHALL return per the Configuration section.

Reset
REQ-024 RST=1 SHALL, without waiting for CLK, force every register to 0 and wr_count to 0.
REQ-025 While RST=1, writes SHALL be ignored and rd_data_a/rd_data_b SHALL read 0 for every address.
REQ-026 A write coincident with the rising edge at which RST is asserted or still high SHALL be discarded; RST deassertion SHALL not itself cause a write.
REQ-027 Reset asserted mid-operation SHALL discard all prior contents; no register SHALL retain pre-reset data.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined: when wr_en=1, RST=0 and rd_addr_x=wr_addr (and not suppressed by ZERO_REG), rd_data_x SHALL equal wr_data combinationally in the same cycle.
REQ-030 Without REGFILE_BYPASS_EN: rd_data_x SHALL return the old stored value until the write edge, then the new value.
REQ-031 All other behaviour, ports and reset SHALL be identical in both builds.

Verification
REQ-032 Reset: RST=1 for 2 cycles after writing 16'h1234 to reg 3 -> rd_data_a at addr 3 = 0, wr_count = 0, both during and after RST.
REQ-033 Write/read: write 16'h0001 to reg 5, 16'h8001 to reg 6 -> next cycle rd_addr_a=5 gives 16'h0001, rd_addr_b=6 gives 16'h8001, wr_count=2.
REQ-034 Zero register (ZERO_REG=1): write 16'hFFFF to reg 0 -> rd_data_a at addr 0 = 0, wr_count unchanged; with ZERO_REG=0 same stimulus reads 16'hFFFF.
REQ-035 Bypass: reg 7 holds 16'h00AA, wr_en=1 wr_addr=7 wr_data=16'h0055, rd_addr_a=7 before edge -> 16'h0055 with REGFILE_BYPASS_EN, 16'h00AA without; both 16'h0055 after edge.
REQ-036 Hold/isolation: fill all 16 regs with value=address*16'h0101, then 20 cycles wr_en=0 -> every register reads its written value via both ports.
REQ-037 Async reset mid-write: assert RST between clock edges while wr_en=1 -> outputs 0 immediately, no write on following edges until RST deasserts.

Source files
------------

// File: rtl/reg_file_if.sv
// Bundles the write port, both read ports and the write counter of reg_file.
// master = the agent issuing reads/writes, slave = the register file itself.
interface reg_file_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic [15:0]       wr_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_count
    );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x WIDTH register file: one write port, two combinational read ports, accepted-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read port addressing the written register.
module reg_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic       CLK,
    input  logic       RST,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [15:0]      r_count;
    logic             w_zero_hit;
    logic             w_accept;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Writes to register 0 are dropped entirely (storage and counter) when it is hardwired.
    assign w_zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign w_accept   = bus.wr_en && !RST && !w_zero_hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else if (w_accept) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
            r_count            <= r_count + 16'd1;
        end
    end

    always_comb begin
        w_rd_a = r_mem[bus.rd_addr_a];
        w_rd_b = r_mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_accept && (bus.rd_addr_a == bus.wr_addr)) w_rd_a = bus.wr_data;
        if (w_accept && (bus.rd_addr_b == bus.wr_addr)) w_rd_b = bus.wr_data;
`endif
        if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) w_rd_a = '0;
        if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) w_rd_b = '0;
        // Storage is already cleared by RST; the mask covers the window before reset propagates.
        if (RST) begin
            w_rd_a = '0;
            w_rd_b = '0;
        end
    end

    assign bus.rd_data_a = w_rd_a;
    assign bus.rd_data_b = w_rd_b;
    assign bus.wr_count  = r_count;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: dut0 has a hardwired register 0, dut1 does not; both see identical stimulus.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(16), .ADDR_W(4)) bus0 ();
    reg_file_if #(.WIDTH(16), .ADDR_W(4)) bus1 ();

    assign bus0.wr_en = wr_en;      assign bus1.wr_en = wr_en;
    assign bus0.wr_addr = wr_addr;  assign bus1.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data;  assign bus1.wr_data = wr_data;
    assign bus0.rd_addr_a = rd_addr_a; assign bus1.rd_addr_a = rd_addr_a;
    assign bus0.rd_addr_b = rd_addr_b; assign bus1.rd_addr_b = rd_addr_b;

    reg_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    reg_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        #1;
    endtask

    task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
        rd_addr_a = a; rd_addr_b = b;
        #1;
    endtask

    logic [15:0] bypass_exp;

    initial begin
        // Power-up reset
        #2;
        read_ab(4'd3, 4'd0);
        check_eq("por_rd_a", bus0.rd_data_a, 0);
        check_eq("por_count", bus0.wr_count, 0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Reset clears a written register, during and after
        write(4'd3, 16'h1234);
        read_ab(4'd3, 4'd3);
        check_eq("pre_rst_rd", bus0.rd_data_a, 16'h1234);
        check_eq("pre_rst_count", bus0.wr_count, 1);
        rst = 1'b1;
        tick(); tick();
        check_eq("rst_during_rd", bus0.rd_data_a, 0);
        check_eq("rst_during_count", bus0.wr_count, 0);
        @(negedge clk); rst = 1'b0;
        tick();
        check_eq("rst_after_rd", bus0.rd_data_a, 0);
        check_eq("rst_after_count", bus0.wr_count, 0);

        // Basic write/read on both ports
        write(4'd5, 16'h0001);
        write(4'd6, 16'h8001);
        read_ab(4'd5, 4'd6);
        check_eq("wr_rd_a5", bus0.rd_data_a, 16'h0001);
        check_eq("wr_rd_b6", bus0.rd_data_b, 16'h8001);
        check_eq("wr_count2", bus0.wr_count, 2);

        // Register 0 behaviour in both configurations
        write(4'd0, 16'hFFFF);
        read_ab(4'd0, 4'd0);
        check_eq("zr1_rd0", bus0.rd_data_a, 0);
        check_eq("zr1_count", bus0.wr_count, 2);
        check_eq("zr0_rd0", bus1.rd_data_b, 16'hFFFF);
        check_eq("zr0_count", bus1.wr_count, 3);

        // Same-cycle read of the register being written
        write(4'd7, 16'h00AA);
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 16'h0055;
`else
        bypass_exp = 16'h00AA;
`endif
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0055;
        read_ab(4'd7, 4'd7);
        check_eq("byp_pre_a", bus0.rd_data_a, bypass_exp);
        check_eq("byp_pre_b", bus0.rd_data_b, bypass_exp);
        tick();
        wr_en = 1'b0;
        #1;
        check_eq("byp_post_a", bus0.rd_data_a, 16'h0055);
        check_eq("byp_count", bus0.wr_count, 4);

        // A write to register 0 is never forwarded when it is hardwired
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        read_ab(4'd0, 4'd7);
        check_eq("byp_zero_a", bus0.rd_data_a, 0);
        @(negedge clk); wr_en = 1'b0;
        tick();

        // Fill, hold for 20 idle cycles, read everything back on both ports
        for (int i = 0; i < 16; i++) write(i[3:0], 16'(i) * 16'h0101);
        repeat (20) tick();
        for (int i = 0; i < 16; i++) begin
            read_ab(i[3:0], 4'(15 - i));
            check_eq($sformatf("hold_a%0d", i), bus0.rd_data_a, (i == 0) ? 0 : 16'(i) * 16'h0101);
            check_eq($sformatf("hold_b%0d", 15 - i), bus0.rd_data_b, (i == 15) ? 0 : 16'(15 - i) * 16'h0101);
        end
        check_eq("hold_count", bus0.wr_count, 19);

        // Asynchronous reset between edges while a write is pending
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hBEEF;
        read_ab(4'd9, 4'd9);
        @(posedge clk); #2;
        check_eq("amid_pre", bus0.rd_data_a, 16'hBEEF);
        rst = 1'b1;
        #1;
        check_eq("amid_rd_a", bus0.rd_data_a, 0);
        check_eq("amid_rd_b", bus0.rd_data_b, 0);
        check_eq("amid_count", bus0.wr_count, 0);
        repeat (3) tick();
        check_eq("amid_hold_rd", bus0.rd_data_a, 0);
        check_eq("amid_hold_count", bus0.wr_count, 0);
        wr_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        check_eq("amid_rel_rd", bus0.rd_data_a, 0);
        check_eq("amid_rel_count", bus0.wr_count, 0);

        // Counter wraps from FFFF to 0
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h0F0F;
        repeat (65535) @(posedge clk);
        #1;
        check_eq("wrap_ffff", bus0.wr_count, 16'hFFFF);
        tick();
        wr_en = 1'b0;
        #1;
        check_eq("wrap_zero", bus0.wr_count, 0);
        check_eq("wrap_zero_zr0", bus1.wr_count, 0);
        read_ab(4'd1, 4'd1);
        check_eq("wrap_data", bus0.rd_data_b, 16'h0F0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
